// File: rtl/dcache_arbiter_pkg.sv
// Shared types for the D-cache load/store arbiter.
//   arb_state_t : arbiter FSM state (IDLE / LOAD / STORE)
//   arb_req_t   : latched D-cache request (addr, rmask, wmask, wdata)
//   AGE_W       : width of the store starvation (age) counter
package dcache_arbiter_pkg;

  localparam int AGE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/dcache_arbiter.sv
// dcache_arbiter: arbitrates a load port and a store port onto a single
// D-cache port with at most one transaction outstanding.
//
// Loads normally win over stores.  A store wins when store_urgent is high
// (store buffer full) or, when the macro DCACHE_ARB_AGING_EN is defined,
// when STARVE_LIMIT loads have been granted while the store was waiting.
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   load_req/addr/rmask       : load request; load_gnt accepts it
//   load_resp, load_rdata     : load completion pulse and read data
//   store_req/addr/wmask/wdata: store request; accepted in IDLE when
//                               store_busy is low
//   store_urgent              : store buffer full, forces store priority
//   store_busy, store_resp    : store back-pressure, completion pulse
//   dcache_addr/rmask/wmask/wdata : request to the D-cache
//   dcache_rdata, dcache_resp     : response from the D-cache
//
// Configuration macro: DCACHE_ARB_AGING_EN (enables the age counter).
module dcache_arbiter
  import dcache_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [3:0]  load_rmask,
  output logic        load_gnt,
  output logic        load_resp,
  output logic [31:0] load_rdata,
  input  logic        store_req,
  input  logic [31:0] store_addr,
  input  logic [3:0]  store_wmask,
  input  logic [31:0] store_wdata,
  input  logic        store_urgent,
  output logic        store_busy,
  output logic        store_resp,
  output logic [31:0] dcache_addr,
  output logic [3:0]  dcache_rmask,
  output logic [3:0]  dcache_wmask,
  output logic [31:0] dcache_wdata,
  input  logic [31:0] dcache_rdata,
  input  logic        dcache_resp
);

  // The age counter is AGE_W bits wide, so the limit must fit in it.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2**AGE_W) - 1) begin : g_limit_check
    $error("dcache_arbiter: STARVE_LIMIT out of range");
  end

  arb_state_t state;
  arb_req_t   req_p1;
  logic       idle;
  logic       store_pri;
  logic       store_gnt;

  assign idle = (state == ST_IDLE);

`ifdef DCACHE_ARB_AGING_EN
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age;

  assign store_pri = store_urgent | (age == AGE_LIMIT);

  // Counts loads that overtook a waiting store; a store grant resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
    end else if (store_gnt) begin
      age <= '0;
    end else if (load_gnt && store_req && (age != AGE_LIMIT)) begin
      age <= age + 1'b1;
    end
  end
`else
  assign store_pri = store_urgent;
`endif

  // While in IDLE, store_busy low is exactly the store grant condition, so
  // load_gnt and store_gnt can never be high together.
  assign store_busy = !idle | (load_req & ~store_pri);
  assign store_gnt  = ~rst & idle & store_req & ~store_busy;
  assign load_gnt   = ~rst & idle & load_req & ~(store_req & store_pri);

  // Stage p0 -> p1: grant latches the request and enters LOAD/STORE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      req_p1 <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (load_gnt) begin
            state  <= ST_LOAD;
            req_p1 <= '{addr: load_addr, rmask: load_rmask,
                        wmask: 4'h0, wdata: 32'h0};
          end else if (store_gnt) begin
            state  <= ST_STORE;
            req_p1 <= '{addr: store_addr, rmask: 4'h0,
                        wmask: store_wmask, wdata: store_wdata};
          end
        end
        ST_LOAD, ST_STORE: begin
          if (dcache_resp) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1 -> D-cache: outputs held from the request registers; gated by
  // rst so an abandoned transaction never shows a mask or response.
  always_comb begin
    dcache_addr  = '0;
    dcache_rmask = '0;
    dcache_wmask = '0;
    dcache_wdata = '0;
    load_resp    = 1'b0;
    store_resp   = 1'b0;
    if (!rst && state == ST_LOAD) begin
      dcache_addr  = req_p1.addr;
      dcache_rmask = req_p1.rmask;
      load_resp    = dcache_resp;
    end else if (!rst && state == ST_STORE) begin
      dcache_addr  = req_p1.addr;
      dcache_wmask = req_p1.wmask;
      dcache_wdata = req_p1.wdata;
      store_resp   = dcache_resp;
    end
  end

  assign load_rdata = load_resp ? dcache_rdata : '0;

endmodule

// File: doc/dcache_arbiter.md
DCACHE_ARBITER -- requirements
Module: dcache_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: number of consecutive load grants allowed while a store waits before the store is forced.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have load-side ports: load_req (in, 1), load_addr (in, 32), load_rmask (in, 4), load_gnt (out, 1), load_resp (out, 1), load_rdata (out, 32).
REQ-005 SHALL have store-side ports: store_req (in, 1), store_addr (in, 32), store_wmask (in, 4), store_wdata (in, 32), store_urgent (in, 1, store buffer full), store_busy (out, 1), store_resp (out, 1).
REQ-006 SHALL have D-cache ports: dcache_addr (out, 32), dcache_rmask (out, 4), dcache_wmask (out, 4), dcache_wdata (out, 32), dcache_rdata (in, 32), dcache_resp (in, 1).

Function
REQ-007 SHALL implement an FSM with states IDLE, LOAD and STORE; only one D-cache transaction is ever outstanding.
REQ-008 SHALL compute store_pri = store_urgent OR (age == STARVE_LIMIT, only when aging is enabled).
REQ-009 SHALL drive store_busy = (state != IDLE) OR (load_req AND NOT store_pri), combinationally.
REQ-010 SHALL treat a store as granted in IDLE when store_req AND NOT store_busy.
REQ-011 SHALL drive load_gnt = (state == IDLE) AND load_req AND NOT (store_req AND store_pri).
REQ-012 SHALL, on a grant edge, latch addr/rmask (load) or addr/wmask/wdata (store) into request registers and move to LOAD or STORE.
REQ-013 SHALL drive the D-cache outputs from the request registers only in LOAD or STORE; in IDLE all masks are 0.
REQ-014 SHALL, in LOAD, drive dcache_rmask = latched rmask and dcache_wmask = 0; in STORE, drive dcache_rmask = 0 and dcache_wmask = latched wmask.
REQ-015 SHALL hold the D-cache outputs stable until dcache_resp, then return to IDLE on that edge; a new grant is possible the following cycle.
REQ-016 SHALL pulse load_resp = dcache_resp in LOAD, with load_rdata = dcache_rdata in the same cycle.
REQ-017 SHALL pulse store_resp = dcache_resp in STORE.
REQ-018 SHALL have a minimum latency of: grant at cycle N, D-cache request visible at N+1, response combinational with dcache_resp.
REQ-019 SHALL ignore dcache_resp while in IDLE.
REQ-020 SHALL keep a 3-bit age counter that increments, saturating at STARVE_LIMIT, on each load grant while store_req is high.
REQ-021 SHALL clear the age counter on any store grant, and SHALL hold it when store_req is low.
REQ-022 SHALL, when load_req and store_req rise together with age 0 and store_urgent low, grant the load first and the store on the first IDLE cycle after the load's response.
REQ-023 SHALL give a store whose store_urgent is asserted priority over a concurrent load, regardless of age.

Reset
REQ-024 SHALL, on rst, set state = IDLE, age = 0 and request registers = 0.
REQ-025 SHALL, during and after rst, output load_gnt, load_resp, store_resp and all D-cache masks as 0, and load_rdata as 0.
REQ-026 SHALL, on rst asserted mid-transaction, abandon the outstanding request without emitting a response; a late dcache_resp is then ignored per REQ-019.

Configuration
REQ-027 SHALL compile the aging counter in when macro DCACHE_ARB_AGING_EN is defined, giving store_pri per REQ-008.
REQ-028 SHALL, without DCACHE_ARB_AGING_EN, omit the counter and use store_pri = store_urgent (strict load priority otherwise); STARVE_LIMIT is then unused.

Structure
REQ-029 SHALL place the arbiter state enum (IDLE/LOAD/STORE) and a packed request struct (addr, rmask, wmask, wdata) in the shared package.
REQ-030 SHALL be a single module with no sub-module; the aging counter is inline.

Verification
REQ-031 SHALL cover: lone load to addr 0x1000 with rmask 0xF, D-cache answering 2 cycles later with 0xDEADBEEF -> load_gnt at N, dcache_rmask 0xF at N+1..N+2, load_resp with load_rdata 0xDEADBEEF at N+2.
REQ-032 SHALL cover: lone store to addr 0x2004, wmask 0x3, data 0x0000ABCD -> store_busy 0, then dcache_wmask 0x3 with dcache_rmask 0, then store_resp on dcache_resp.
REQ-033 SHALL cover: load and store asserted together, store_urgent 0, age 0 -> load served first, store granted the cycle after load_resp.
REQ-034 SHALL cover: aging enabled, STARVE_LIMIT 4, store held high through 5 back-to-back loads -> loads 1-4 granted, store granted before load 5, age returns to 0.
REQ-035 SHALL cover: store_urgent 1 with a concurrent load -> store granted and load_gnt 0; rst mid-LOAD followed by dcache_resp -> state IDLE and no load_resp.
